// File: rtl/wvfm_lut_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : wvfm_lut_loader
// Description : Loads the 16K x 2-bit EPD waveform lookup RAM through its
//               port A write interface.
//
//               Host words (12-bit word address, four packed 2-bit entries)
//               are queued in a small FIFO. Each word is then unpacked into
//               four RAM writes. A write is issued only in cycles where the
//               scan pipeline is not reading the LUT. The module also tracks
//               whether a complete, committed table is present in the RAM.
//
// Ports       : clk, rst        - clock and synchronous active-high reset
//               host_valid      - host word valid
//               host_ready      - FIFO can accept a word (not full)
//               host_addr[11:0] - LUT word address (LUT address[13:2])
//               host_data[7:0]  - entry k in bits [2k+1:2k]
//               host_commit     - one-cycle pulse marking end of a table load
//               lut_rd_active   - pipeline is reading the LUT this cycle
//               ram_we          - LUT port A write enable
//               ram_addr_wr     - LUT write address (14 bits)
//               ram_wr          - LUT write data (2 bits)
//               table_valid     - committed table present, no writes since
//               busy            - FIFO non-empty, unpacking or commit pending
//               wr_count        - number of RAM write cycles (wraps)
//
// Revision    : 1.0 - initial release
// ============================================================================
module wvfm_lut_loader #(
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [11:0] host_addr,
    input  logic [7:0]  host_data,
    input  logic        host_commit,
    input  logic        lut_rd_active,
    output logic        ram_we,
    output logic [13:0] ram_addr_wr,
    output logic [1:0]  ram_wr,
    output logic        table_valid,
    output logic        busy,
    output logic [15:0] wr_count
);

    localparam int               c_DEPTH    = 1 << FIFO_AW;
    localparam int               c_ENTRY_W  = 20;
    localparam logic [FIFO_AW:0] c_PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [1:0]       c_LAST_SUB = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_UNPACK = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // FIFO entry layout: {word address[11:0], packed data[7:0]}
    logic [c_ENTRY_W-1:0] r_fifo_mem [c_DEPTH];
    // Pointers carry one extra wrap bit so full and empty can be told apart
    logic [FIFO_AW:0]     r_wr_ptr;
    logic [FIFO_AW:0]     r_rd_ptr;

    state_t               r_state;
    logic [11:0]          r_hold_addr;
    logic [7:0]           r_hold_data;
    logic [1:0]           r_sub;
    logic [13:0]          r_ram_addr_wr;
    logic [1:0]           r_ram_wr;
    logic                 r_commit_pending;
    logic                 r_table_valid;
    logic [15:0]          r_wr_count;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ram_we;
    logic                 w_commit_done;
    logic [c_ENTRY_W-1:0] w_head;
    logic [1:0]           w_sub_next;
    logic [1:0]           w_next_entry;

    // ------------------------------------------------------------------------
    // FIFO status, all from registered pointers
    // ------------------------------------------------------------------------
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);

    // A pop on a full FIFO frees a slot only after the edge, so host_ready
    // stays low in that cycle and a push can never land on a full FIFO.
    assign w_push  = host_valid && !w_full;
    // Popping is not gated by lut_rd_active: loading the hold register does
    // not touch the RAM port.
    assign w_pop   = (r_state == ST_IDLE) && !w_empty;
    assign w_head  = r_fifo_mem[r_rd_ptr[FIFO_AW-1:0]];

    // The only input-to-output combinational path: a write is withdrawn in
    // any cycle the pipeline claims the port.
    assign w_ram_we = (r_state == ST_UNPACK) && !lut_rd_active;

    // Next entry to present after a successful write
    assign w_sub_next   = r_sub + 2'd1;
    assign w_next_entry = r_hold_data[{w_sub_next, 1'b0} +: 2];

    // A word arriving on the same edge as the commit would finish keeps the
    // commit pending, so the table is never marked valid with data queued.
    assign w_commit_done = r_commit_pending && w_empty &&
                           (r_state == ST_IDLE) && !w_push;

    // ------------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are qualified by the pointers)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr[FIFO_AW-1:0]] <= {host_addr, host_data};
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Unpack FSM with registered write address / data
    // ------------------------------------------------------------------------
    // ram_addr_wr / ram_wr always show the entry the next write will use, so
    // they are loaded for sub 0 on the pop and advanced after each write.
    // A stalled cycle leaves everything untouched, which is what guarantees
    // no entry is skipped or repeated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_hold_addr   <= '0;
            r_hold_data   <= '0;
            r_sub         <= '0;
            r_ram_addr_wr <= '0;
            r_ram_wr      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_hold_addr   <= w_head[19:8];
                        r_hold_data   <= w_head[7:0];
                        r_sub         <= 2'd0;
                        r_ram_addr_wr <= {w_head[19:8], 2'd0};
                        r_ram_wr      <= w_head[1:0];
                        r_state       <= ST_UNPACK;
                    end
                end
                ST_UNPACK: begin
                    if (!lut_rd_active) begin
                        if (r_sub == c_LAST_SUB) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_sub         <= w_sub_next;
                            r_ram_addr_wr <= {r_hold_addr, w_sub_next};
                            r_ram_wr      <= w_next_entry;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Commit tracking and write counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_commit_pending <= 1'b0;
            r_table_valid    <= 1'b0;
            r_wr_count       <= '0;
        end else begin
            // A commit pulse that arrives while one is pending is absorbed
            if (w_commit_done) begin
                r_commit_pending <= 1'b0;
            end else if (host_commit) begin
                r_commit_pending <= 1'b1;
            end

            // Any accepted word invalidates the table on its accept edge
            if (w_push) begin
                r_table_valid <= 1'b0;
            end else if (w_commit_done) begin
                r_table_valid <= 1'b1;
            end

            if (w_ram_we) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign host_ready  = !w_full;
    assign ram_we      = w_ram_we;
    assign ram_addr_wr = r_ram_addr_wr;
    assign ram_wr      = r_ram_wr;
    assign table_valid = r_table_valid;
    assign busy        = !w_empty || (r_state == ST_UNPACK) || r_commit_pending;
    assign wr_count    = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_wvfm_lut_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_wvfm_lut_loader
// Description : Self-checking bench for wvfm_lut_loader. A scoreboard queue
//               holds every LUT write the host words imply (address, entry)
//               in acceptance order; each ram_we cycle must match the head.
//               Scenario tasks check timing of ready/valid/busy directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wvfm_lut_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [11:0] host_addr = '0;
    logic [7:0]  host_data = '0;
    logic        host_commit = 1'b0;
    logic        lut_rd_active = 1'b0;
    logic        ram_we;
    logic [13:0] ram_addr_wr;
    logic [1:0]  ram_wr;
    logic        table_valid;
    logic        busy;
    logic [15:0] wr_count;

    int          checks = 0;
    int          errors = 0;

    // Reference model: pending writes {addr[13:0], data[1:0]} in order
    logic [15:0] exp_q[$];
    logic [15:0] exp_w;
    int          model_cnt = 0;
    int          exp_total = 0;
    bit          mon_en = 1'b0;

    wvfm_lut_loader #(.FIFO_AW(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .host_valid   (host_valid),
        .host_ready   (host_ready),
        .host_addr    (host_addr),
        .host_data    (host_data),
        .host_commit  (host_commit),
        .lut_rd_active(lut_rd_active),
        .ram_we       (ram_we),
        .ram_addr_wr  (ram_addr_wr),
        .ram_wr       (ram_wr),
        .table_valid  (table_valid),
        .busy         (busy),
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (wr_count !== 16'(model_cnt)) begin
                errors++;
                $display("FAIL wr_count_track: got %0d expected %0d at %0t", wr_count, 16'(model_cnt), $time);
            end
            if (lut_rd_active === 1'b1) begin
                checks++;
                if (ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL we_during_read: ram_we=%b expected 0 at %0t", ram_we, $time);
                end
            end
            if (rst) begin
                exp_q.delete();
                model_cnt = 0;
            end else begin
                if (host_valid && host_ready) begin
                    for (int k = 0; k < 4; k++) begin
                        exp_q.push_back({host_addr, 2'(k), host_data[2*k +: 2]});
                    end
                end
                if (ram_we === 1'b1) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write: addr %h data %0d with no write expected at %0t", ram_addr_wr, ram_wr, $time);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if ({ram_addr_wr, ram_wr} !== exp_w) begin
                            errors++;
                            $display("FAIL write_order: got addr %h data %0d expected addr %h data %0d at %0t", ram_addr_wr, ram_wr, exp_w[15:2], exp_w[1:0], $time);
                        end
                    end
                    model_cnt = (model_cnt + 1) & 32'hFFFF;
                end
            end
        end
    end

    // Wait for all expected writes and for busy to drop, then check count
    task automatic drain(input int bound, input bit rand_lut);
        int n;
        n = 0;
        host_valid  = 1'b0;
        host_commit = 1'b0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && n < bound) begin
            lut_rd_active = rand_lut ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk); #1;
            n++;
        end
        lut_rd_active = 1'b0;
        checks++;
        if (n >= bound) begin
            errors++;
            $display("FAIL drain_timeout: %0d writes still expected, busy=%b after %0d cycles", exp_q.size(), busy, n);
        end
        @(negedge clk);
        checks++;
        if (wr_count !== 16'(exp_total)) begin
            errors++;
            $display("FAIL drain_wr_count: got %0d expected %0d", wr_count, 16'(exp_total));
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        checks++; if (host_ready  !== 1'b1)  begin errors++; $display("FAIL %s host_ready: got %b expected 1", tag, host_ready); end
        checks++; if (ram_we      !== 1'b0)  begin errors++; $display("FAIL %s ram_we: got %b expected 0", tag, ram_we); end
        checks++; if (ram_addr_wr !== 14'd0) begin errors++; $display("FAIL %s ram_addr_wr: got %h expected 0", tag, ram_addr_wr); end
        checks++; if (ram_wr      !== 2'd0)  begin errors++; $display("FAIL %s ram_wr: got %0d expected 0", tag, ram_wr); end
        checks++; if (table_valid !== 1'b0)  begin errors++; $display("FAIL %s table_valid: got %b expected 0", tag, table_valid); end
        checks++; if (busy        !== 1'b0)  begin errors++; $display("FAIL %s busy: got %b expected 0", tag, busy); end
        checks++; if (wr_count    !== 16'd0) begin errors++; $display("FAIL %s wr_count: got %0d expected 0", tag, wr_count); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        host_valid = 1'b0; host_commit = 1'b0; lut_rd_active = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst       = 1'b0;
        model_cnt = 0;
        exp_total = 0;
        mon_en    = 1'b1;
    endtask

    // Word 0x123 / 0xE4: writes 0x48C..0x48F with data 0..3, two cycles after accept
    task automatic test_single();
        logic exp_we;
        host_addr = 12'h123; host_data = 8'hE4; host_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (host_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", host_ready); end
        @(posedge clk); #1;
        host_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_we = (c >= 2 && c <= 5);
            checks++;
            if (ram_we !== exp_we) begin errors++; $display("FAIL single_we cycle %0d: got %b expected %b", c, ram_we, exp_we); end
            if (exp_we) begin
                checks++;
                if (ram_addr_wr !== 14'(14'h48C + c - 2) || ram_wr !== 2'(c - 2)) begin
                    errors++;
                    $display("FAIL single_write cycle %0d: got addr %h data %0d expected addr %h data %0d", c, ram_addr_wr, ram_wr, 14'(14'h48C + c - 2), 2'(c - 2));
                end
            end
            @(posedge clk); #1;
        end
        exp_total += 4;
        drain(50, 1'b0);
    endtask

    // Stall for 10 cycles after the second write of a 0x1B word
    task automatic test_stall();
        logic [7:0] d;
        logic       exp_we;
        int         sub;
        int         writes;
        d = 8'h1B;
        writes = 0;
        host_addr = 12'h2A5; host_data = d; host_valid = 1'b1;
        @(posedge clk); #1;
        host_valid = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            lut_rd_active = (c >= 4 && c <= 13);
            @(negedge clk);
            exp_we = (c == 2 || c == 3 || c == 14 || c == 15);
            sub    = (c < 4) ? c - 2 : c - 12;
            checks++;
            if (ram_we !== exp_we) begin errors++; $display("FAIL stall_we cycle %0d: got %b expected %b", c, ram_we, exp_we); end
            if (ram_we === 1'b1) writes++;
            if (exp_we) begin
                checks++;
                if (ram_addr_wr !== {12'h2A5, 2'(sub)} || ram_wr !== d[2*sub +: 2]) begin
                    errors++;
                    $display("FAIL stall_write cycle %0d: got addr %h data %0d expected addr %h data %0d", c, ram_addr_wr, ram_wr, {12'h2A5, 2'(sub)}, d[2*sub +: 2]);
                end
            end
            @(posedge clk); #1;
        end
        lut_rd_active = 1'b0;
        checks++;
        if (writes != 4) begin errors++; $display("FAIL stall_total_writes: got %0d expected 4", writes); end
        exp_total += 4;
        drain(50, 1'b0);
    endtask

    // 18 words offered with the port blocked. The first word moves into the
    // hold register, so 1 + 16 words are taken before host_ready falls.
    // After release, the pop at cycle 24 frees a slot visible in cycle 25.
    task automatic test_fifo_full();
        logic [11:0] wa[18];
        logic [7:0]  wd[18];
        logic        exp_rdy;
        int          nacc;
        nacc = 0;
        for (int i = 0; i < 18; i++) begin
            wa[i] = 12'($urandom);
            wd[i] = 8'($urandom);
        end
        for (int c = 0; c <= 25; c++) begin
            lut_rd_active = (c < 20);
            host_valid    = 1'b1;
            host_addr     = wa[nacc];
            host_data     = wd[nacc];
            @(negedge clk);
            exp_rdy = (c <= 16) || (c == 25);
            checks++;
            if (host_ready !== exp_rdy) begin errors++; $display("FAIL fifo_ready cycle %0d: got %b expected %b", c, host_ready, exp_rdy); end
            if (exp_rdy) nacc++;
            @(posedge clk); #1;
        end
        host_valid = 1'b0;
        lut_rd_active = 1'b0;
        exp_total += 72;
        drain(300, 1'b0);
    endtask

    // Three words then a commit: table_valid rises / busy falls at cycle 17
    task automatic test_commit();
        for (int c = 0; c <= 20; c++) begin
            host_valid  = (c <= 2);
            host_addr   = 12'($urandom);
            host_data   = 8'($urandom);
            host_commit = (c == 3);
            @(negedge clk);
            if (c <= 2) begin
                checks++;
                if (host_ready !== 1'b1) begin errors++; $display("FAIL commit_ready cycle %0d: got %b expected 1", c, host_ready); end
            end else begin
                checks++;
                if (table_valid !== (c >= 17)) begin errors++; $display("FAIL commit_valid cycle %0d: got %b expected %b", c, table_valid, (c >= 17)); end
                checks++;
                if (busy !== (c < 17)) begin errors++; $display("FAIL commit_busy cycle %0d: got %b expected %b", c, busy, (c < 17)); end
            end
            @(posedge clk); #1;
        end
        host_valid = 1'b0; host_commit = 1'b0;
        exp_total += 12;
        // A later word invalidates the table on its accept edge
        host_valid = 1'b1; host_addr = 12'($urandom); host_data = 8'($urandom);
        @(negedge clk);
        checks++;
        if (table_valid !== 1'b1) begin errors++; $display("FAIL commit_hold_valid: got %b expected 1", table_valid); end
        @(posedge clk); #1;
        host_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (table_valid !== 1'b0) begin errors++; $display("FAIL commit_invalidate: got %b expected 0", table_valid); end
        @(posedge clk); #1;
        exp_total += 4;
        drain(100, 1'b0);
    endtask

    // Commit with an accepted word while valid; a second pulse at cycle 6 is absorbed
    task automatic test_same_cycle_commit();
        logic exp_v;
        for (int c = 0; c <= 12; c++) begin
            host_commit = (c == 0 || c == 3 || c == 6);
            host_valid  = (c == 3);
            host_addr   = 12'($urandom);
            host_data   = 8'($urandom);
            @(negedge clk);
            if (c == 3) begin
                checks++;
                if (host_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b expected 1", host_ready); end
            end
            if (c >= 2) begin
                exp_v = (c == 2 || c == 3 || c >= 10);
                checks++;
                if (table_valid !== exp_v) begin errors++; $display("FAIL same_valid cycle %0d: got %b expected %b", c, table_valid, exp_v); end
            end
            @(posedge clk); #1;
        end
        host_valid = 1'b0; host_commit = 1'b0;
        exp_total += 4;
        drain(100, 1'b0);
    endtask

    // Random words with random port contention; order checked by the scoreboard
    task automatic test_random();
        int  sent;
        int  n;
        bit  offering;
        sent = 0; n = 0; offering = 1'b0;
        while (sent < 40 && n < 3000) begin
            if (!offering && $urandom_range(0, 3) != 0) begin
                offering  = 1'b1;
                host_addr = 12'($urandom);
                host_data = 8'($urandom);
            end
            host_valid    = offering;
            host_commit   = 1'b0;
            lut_rd_active = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            if (offering && host_ready === 1'b1) begin
                offering = 1'b0;
                sent++;
            end
            @(posedge clk); #1;
            n++;
        end
        host_valid = 1'b0;
        checks++;
        if (sent != 40) begin errors++; $display("FAIL random_accept: got %0d words accepted expected 40", sent); end
        exp_total += 4 * sent;
        drain(600, 1'b1);
    endtask

    // Five words queued, reset after the first write: nothing else is written
    task automatic test_reset_mid_unpack();
        int we_seen;
        for (int c = 0; c <= 4; c++) begin
            lut_rd_active = 1'b1;
            host_valid    = 1'b1;
            host_addr     = 12'($urandom);
            host_data     = 8'($urandom);
            @(posedge clk); #1;
        end
        host_valid    = 1'b0;
        lut_rd_active = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_we !== 1'b1) begin errors++; $display("FAIL rmid_first_write: got %b expected 1", ram_we); end
        @(posedge clk); #1;
        rst = 1'b1;
        lut_rd_active = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        lut_rd_active = 1'b0;
        exp_total = 0;
        @(negedge clk);
        check_reset_values("rmid");
        we_seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (ram_we === 1'b1) we_seen++;
        end
        checks++;
        if (we_seen != 0) begin errors++; $display("FAIL rmid_no_writes: got %0d write cycles expected 0", we_seen); end
        checks++;
        if (wr_count !== 16'd0) begin errors++; $display("FAIL rmid_wr_count: got %0d expected 0", wr_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_fifo_full();
        test_commit();
        test_same_cycle_commit();
        test_random();
        test_reset_mid_unpack();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
